// File: rtl/fll_lock_ctrl_if.sv
// Register bus, acquisition control and NCO/status outputs of the FLL lock controller.
interface fll_lock_ctrl_if;
  logic        wr_en;
  logic [2:0]  address;
  logic [31:0] data;
  logic        start;
  logic [31:0] delta;
  logic        delta_valid;
  logic [31:0] phi_inc;
  logic        phi_valid;
  logic        fll_en;
  logic        nco_en;
  logic        locked;
  logic        busy;
  logic [2:0]  state;

  modport master (
    output wr_en, address, data, start, delta, delta_valid,
    input  phi_inc, phi_valid, fll_en, nco_en, locked, busy, state
  );

  modport slave (
    input  wr_en, address, data, start, delta, delta_valid,
    output phi_inc, phi_valid, fll_en, nco_en, locked, busy, state
  );
endinterface

// File: rtl/fll_lock_ctrl.sv
// FLL acquisition controller: coarse NCO frequency sweep, then proportional tracking
// of the FLL frequency error with lock detection.
module fll_lock_ctrl #(
  parameter int MULT        = 300_000,
  parameter int PHI_DEFAULT = 36_151_557,
  parameter int DWELL       = 64
) (
  input logic            clk,
  input logic            reset,
  fll_lock_ctrl_if.slave bus
);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_SWEEP  = 3'd1;
  localparam logic [2:0] S_TRACK  = 3'd2;
  localparam logic [2:0] S_LOCKED = 3'd3;
  localparam logic [2:0] S_FAIL   = 3'd4;

  localparam int            DW         = (DWELL > 1) ? $clog2(DWELL) : 1;
  localparam logic [DW-1:0] DWELL_LAST = DW'(DWELL - 1);
  localparam logic [DW-1:0] DWELL_ONE  = DW'(1);
  localparam logic [DW-1:0] DWELL_ZERO = DW'(0);
  localparam logic [31:0]   MULT_W     = 32'(MULT);
  localparam logic [31:0]   PHI_RST    = 32'(PHI_DEFAULT);

  // |v| with the most negative value saturating to the largest positive one
  function automatic logic [31:0] abs_sat(input logic [31:0] v);
    if (v == 32'h8000_0000) begin
      abs_sat = 32'h7FFF_FFFF;
    end else if (v[31]) begin
      abs_sat = 32'd0 - v;
    end else begin
      abs_sat = v;
    end
  endfunction

  logic [31:0]   phi_init_r, step_r, lock_thr_r;
  logic [15:0]   sweep_cnt_r, lock_len_r;
  logic [2:0]    state_r, state_nx_s;
  logic [31:0]   phi_inc_r, phi_nx_s;
  logic          phi_valid_r, phv_nx_s;
  logic          fll_en_r, nco_en_r, locked_r, busy_r;
  logic [15:0]   k_r, k_nx_s, cnt_r, cnt_nx_s;
  logic [DW-1:0] dwell_r, dwell_nx_s;
  logic          hit_r, hit_nx_s;
  logic [31:0]   prod_r, prod_nx_s;
  logic          prod_vld_r, pvld_nx_s;

  logic        ctrl_wr_s, cfg_wr_s, go_s, abort_s, trk_s, in_band_s, end_hit_s;
  logic [15:0] lock_len_eff_s, cnt_inc_s;

  assign ctrl_wr_s      = bus.wr_en && (bus.address == 3'd5);
  assign cfg_wr_s       = bus.wr_en && !busy_r && (bus.address <= 3'd4);
  assign go_s           = bus.start || (ctrl_wr_s && bus.data[0]);
  assign abort_s        = ctrl_wr_s && bus.data[1];
  assign trk_s          = (state_r == S_TRACK) || (state_r == S_LOCKED);
  assign in_band_s      = bus.delta_valid && (abs_sat(bus.delta) <= lock_thr_r);
  assign end_hit_s      = bus.delta_valid ? in_band_s : hit_r;
  assign lock_len_eff_s = (lock_len_r == 16'd0) ? 16'd1 : lock_len_r;
  assign cnt_inc_s      = cnt_r + 16'd1;

  // Configuration registers; frozen while an acquisition is in progress
  always_ff @(posedge clk) begin
    if (reset) begin
      phi_init_r  <= PHI_RST;
      step_r      <= 32'd0;
      sweep_cnt_r <= 16'd0;
      lock_thr_r  <= 32'd1000;
      lock_len_r  <= 16'd16;
    end else if (cfg_wr_s) begin
      case (bus.address)
        3'd0:    phi_init_r  <= bus.data;
        3'd1:    step_r      <= bus.data;
        3'd2:    sweep_cnt_r <= bus.data[15:0];
        3'd3:    lock_thr_r  <= bus.data;
        3'd4:    lock_len_r  <= bus.data[15:0];
        default: phi_init_r  <= phi_init_r;
      endcase
    end
  end

  // Next-state, sweep bookkeeping and tracking update of phi_inc
  always_comb begin
    state_nx_s = state_r;
    phi_nx_s   = phi_inc_r;
    phv_nx_s   = 1'b0;
    k_nx_s     = k_r;
    dwell_nx_s = dwell_r;
    hit_nx_s   = hit_r;
    cnt_nx_s   = cnt_r;
    pvld_nx_s  = trk_s && bus.delta_valid;
    prod_nx_s  = bus.delta * MULT_W;
    if (abort_s) begin
      state_nx_s = S_IDLE;
      phi_nx_s   = phi_init_r;
      pvld_nx_s  = 1'b0;
      k_nx_s     = 16'd0;
      dwell_nx_s = DWELL_ZERO;
      hit_nx_s   = 1'b0;
      cnt_nx_s   = 16'd0;
    end else begin
      case (state_r)
        S_IDLE, S_FAIL: begin
          if (go_s) begin
            phi_nx_s   = phi_init_r;
            k_nx_s     = 16'd0;
            dwell_nx_s = DWELL_ZERO;
            hit_nx_s   = 1'b0;
            cnt_nx_s   = 16'd0;
            if (sweep_cnt_r != 16'd0) begin
              state_nx_s = S_SWEEP;
            end else begin
              state_nx_s = S_TRACK;
            end
          end else if (state_r == S_IDLE) begin
            phi_nx_s = phi_init_r;
          end else begin
            phi_nx_s = phi_inc_r;
          end
        end
        S_SWEEP: begin
          if (dwell_r == DWELL_LAST) begin
            dwell_nx_s = DWELL_ZERO;
            hit_nx_s   = 1'b0;
            if (end_hit_s) begin
              state_nx_s = S_TRACK;
              cnt_nx_s   = 16'd0;
            end else if ((k_r + 16'd1) == sweep_cnt_r) begin
              state_nx_s = S_FAIL;
              k_nx_s     = k_r + 16'd1;
            end else begin
              k_nx_s   = k_r + 16'd1;
              phi_nx_s = phi_inc_r + step_r;
              phv_nx_s = 1'b1;
            end
          end else begin
            dwell_nx_s = dwell_r + DWELL_ONE;
            hit_nx_s   = end_hit_s;
          end
        end
        S_TRACK, S_LOCKED: begin
          // Second pipeline stage: apply the product registered last cycle
          if (prod_vld_r) begin
            phi_nx_s = phi_inc_r - prod_r;
            phv_nx_s = 1'b1;
          end else begin
            phi_nx_s = phi_inc_r;
          end
          if (bus.delta_valid && !in_band_s) begin
            state_nx_s = S_TRACK;
            cnt_nx_s   = 16'd0;
          end else if (in_band_s && (state_r == S_TRACK)) begin
            cnt_nx_s = cnt_inc_s;
            if (cnt_inc_s >= lock_len_eff_s) begin
              state_nx_s = S_LOCKED;
            end else begin
              state_nx_s = S_TRACK;
            end
          end else begin
            cnt_nx_s = cnt_r;
          end
        end
        default: begin
          state_nx_s = S_IDLE;
          phi_nx_s   = phi_init_r;
          pvld_nx_s  = 1'b0;
        end
      endcase
    end
  end

  // State, datapath and registered status outputs
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r     <= S_IDLE;
      phi_inc_r   <= PHI_RST;
      phi_valid_r <= 1'b0;
      k_r         <= 16'd0;
      dwell_r     <= DWELL_ZERO;
      hit_r       <= 1'b0;
      cnt_r       <= 16'd0;
      prod_r      <= 32'd0;
      prod_vld_r  <= 1'b0;
      fll_en_r    <= 1'b0;
      nco_en_r    <= 1'b0;
      locked_r    <= 1'b0;
      busy_r      <= 1'b0;
    end else begin
      state_r     <= state_nx_s;
      phi_inc_r   <= phi_nx_s;
      phi_valid_r <= phv_nx_s;
      k_r         <= k_nx_s;
      dwell_r     <= dwell_nx_s;
      hit_r       <= hit_nx_s;
      cnt_r       <= cnt_nx_s;
      prod_r      <= prod_nx_s;
      prod_vld_r  <= pvld_nx_s;
      fll_en_r    <= (state_nx_s == S_TRACK) || (state_nx_s == S_LOCKED);
      nco_en_r    <= (state_nx_s == S_SWEEP) || (state_nx_s == S_TRACK) ||
                     (state_nx_s == S_LOCKED);
      locked_r    <= (state_nx_s == S_LOCKED);
      busy_r      <= (state_nx_s == S_SWEEP) || (state_nx_s == S_TRACK) ||
                     (state_nx_s == S_LOCKED);
    end
  end

  assign bus.phi_inc   = phi_inc_r;
  assign bus.phi_valid = phi_valid_r;
  assign bus.fll_en    = fll_en_r;
  assign bus.nco_en    = nco_en_r;
  assign bus.locked    = locked_r;
  assign bus.busy      = busy_r;
  assign bus.state     = state_r;

endmodule

// File: tb/tb_fll_lock_ctrl.sv
// Directed + randomized bench for fll_lock_ctrl with a scheduled-event tracking model.
module tb_fll_lock_ctrl;

  localparam int          MULT = 300_000;
  localparam logic [31:0] PHI0 = 32'd36_151_557;

  logic clk;
  logic reset;
  fll_lock_ctrl_if bus ();

  fll_lock_ctrl #(.MULT(MULT), .PHI_DEFAULT(36_151_557), .DWELL(64)) dut (
    .clk(clk), .reset(reset), .bus(bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  // tracking model: pending phi adjustments keyed by the edge they become visible
  logic [31:0] phi_m;
  int          run_m;
  bit          lk_m;
  longint      thr_m;
  int          len_m;
  int          n_m;
  int          due_q[$];
  logic [31:0] amt_q[$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [2:0] a, input logic [31:0] d);
    bus.wr_en = 1'b1; bus.address = a; bus.data = d;
    step();
    bus.wr_en = 1'b0;
  endtask

  task automatic model_init(input logic [31:0] phi, input longint thr, input int len);
    phi_m = phi; run_m = 0; lk_m = 1'b0; thr_m = thr; len_m = len; n_m = 0;
    due_q.delete(); amt_q.delete();
  endtask

  function automatic longint mag(input logic [31:0] d);
    longint a;
    a = longint'($signed(d));
    if (a < 0) a = -a;
    if (a > 64'sd2147483647) a = 64'sd2147483647;
    return a;
  endfunction

  task automatic trk_step(input bit v, input logic [31:0] d);
    bit pv;
    bus.delta_valid = v; bus.delta = d;
    if (v) begin
      due_q.push_back(n_m + 1);
      amt_q.push_back(32'(longint'($signed(d)) * longint'(MULT)));
      if (mag(d) <= thr_m) begin
        run_m++;
        if (run_m >= ((len_m == 0) ? 1 : len_m)) lk_m = 1'b1;
      end else begin
        run_m = 0; lk_m = 1'b0;
      end
    end
    step();
    bus.delta_valid = 1'b0;
    pv = 1'b0;
    while (due_q.size() > 0 && due_q[0] <= n_m) begin
      phi_m = phi_m - amt_q[0];
      void'(due_q.pop_front()); void'(amt_q.pop_front());
      pv = 1'b1;
    end
    n_m++;
    chk("trk_phi", bus.phi_inc, phi_m);
    chk("trk_pv", 32'(bus.phi_valid), 32'(pv));
    chk("trk_locked", 32'(bus.locked), 32'(lk_m));
    chk("trk_state", 32'(bus.state), lk_m ? 32'd3 : 32'd2);
  endtask

  initial begin
    logic [31:0] d;
    bus.wr_en = 1'b0; bus.address = 3'd0; bus.data = 32'd0;
    bus.start = 1'b0; bus.delta = 32'd0; bus.delta_valid = 1'b0;
    reset = 1'b1;
    step(); step();
    reset = 1'b0;
    step();
    chk("rst_phi", bus.phi_inc, PHI0);
    chk("rst_state", 32'(bus.state), 32'd0);
    chk("rst_pv", 32'(bus.phi_valid), 32'd0);
    chk("rst_fll", 32'(bus.fll_en), 32'd0);
    chk("rst_nco", 32'(bus.nco_en), 32'd0);
    chk("rst_locked", 32'(bus.locked), 32'd0);
    chk("rst_busy", 32'(bus.busy), 32'd0);

    // sweep that never finds the band
    wr(3'd1, 32'd1000);
    wr(3'd2, 32'd3);
    bus.delta = 32'd50000; bus.delta_valid = 1'b1;
    bus.start = 1'b1; step(); bus.start = 1'b0;
    chk("sw_state0", 32'(bus.state), 32'd1);
    chk("sw_nco", 32'(bus.nco_en), 32'd1);
    chk("sw_fll", 32'(bus.fll_en), 32'd0);
    chk("sw_busy", 32'(bus.busy), 32'd1);
    chk("sw_phi0", bus.phi_inc, PHI0);
    for (int i = 1; i <= 192; i++) begin
      step();
      chk("sw_phi", bus.phi_inc, PHI0 + ((i >= 64) ? 32'd1000 : 32'd0) + ((i >= 128) ? 32'd1000 : 32'd0));
      chk("sw_pv", 32'(bus.phi_valid), 32'((i == 64) || (i == 128)));
      chk("sw_state", 32'(bus.state), (i < 192) ? 32'd1 : 32'd4);
    end
    bus.delta_valid = 1'b0;
    chk("fail_nco", 32'(bus.nco_en), 32'd0);
    chk("fail_busy", 32'(bus.busy), 32'd0);
    step(); step(); step();
    chk("fail_hold", bus.phi_inc, PHI0 + 32'd2000);

    // restart from FAIL; band found in the second dwell, stray start ignored
    wr(3'd2, 32'd4);
    bus.start = 1'b1; step(); bus.start = 1'b0;
    chk("rs_state", 32'(bus.state), 32'd1);
    chk("rs_phi", bus.phi_inc, PHI0);
    for (int i = 1; i <= 128; i++) begin
      bus.delta_valid = (i == 5) || (i == 20) || (i == 100);
      bus.delta = (i == 20) ? 32'd50000 : 32'd10;
      bus.start = (i == 30);
      step();
      chk("acq_phi", bus.phi_inc, PHI0 + ((i >= 64) ? 32'd1000 : 32'd0));
      chk("acq_pv", 32'(bus.phi_valid), 32'(i == 64));
      chk("acq_state", 32'(bus.state), (i < 128) ? 32'd1 : 32'd2);
    end
    bus.start = 1'b0; bus.delta_valid = 1'b0;
    chk("acq_fll", 32'(bus.fll_en), 32'd1);

    // tracking gain and latency
    model_init(PHI0 + 32'd1000, 1000, 16);
    trk_step(1'b1, 32'd2);
    trk_step(1'b0, 32'd0);
    chk("gain_pos", bus.phi_inc, PHI0 + 32'd1000 - 32'd600000);
    trk_step(1'b0, 32'd0);
    trk_step(1'b1, 32'hFFFF_FFFF);
    trk_step(1'b0, 32'd0);
    chk("gain_neg", bus.phi_inc, PHI0 + 32'd1000 - 32'd300000);

    // lock after 16 consecutive in-band samples, drop on out-of-band
    trk_step(1'b1, 32'd5000);
    for (int k = 1; k <= 16; k++) begin
      d = (k == 1) ? 32'd1000 : (k == 2) ? 32'hFFFF_FC18 : (32'($urandom_range(2000, 0)) - 32'd1000);
      trk_step(1'b1, d);
      if (k == 15) chk("lock_early", 32'(bus.locked), 32'd0);
    end
    chk("lock_set", 32'(bus.locked), 32'd1);
    chk("lock_state", 32'(bus.state), 32'd3);
    trk_step(1'b1, 32'd5000);
    chk("lock_drop", 32'(bus.locked), 32'd0);
    chk("lock_back", 32'(bus.state), 32'd2);

    // randomized tracking traffic
    for (int r = 0; r < 300; r++) begin
      d = ($urandom_range(7, 0) == 0) ? $urandom() : (32'($urandom_range(2000, 0)) - 32'd1000);
      trk_step(1'($urandom_range(1, 0)), d);
    end

    // abort in LOCKED with products in flight
    for (int k = 0; k < 16; k++) trk_step(1'b1, 32'd3);
    chk("pre_abort_lk", 32'(bus.state), 32'd3);
    trk_step(1'b1, 32'd7);
    bus.wr_en = 1'b1; bus.address = 3'd5; bus.data = 32'd2;
    bus.delta_valid = 1'b1; bus.delta = 32'd9;
    step();
    bus.wr_en = 1'b0; bus.delta_valid = 1'b0;
    chk("ab_state", 32'(bus.state), 32'd0);
    chk("ab_phi", bus.phi_inc, PHI0);
    chk("ab_locked", 32'(bus.locked), 32'd0);
    chk("ab_fll", 32'(bus.fll_en), 32'd0);
    for (int k = 0; k < 4; k++) begin
      chk("ab_pv", 32'(bus.phi_valid), 32'd0);
      step();
      chk("ab_phi_hold", bus.phi_inc, PHI0);
    end

    // abort beats start, and CTRL go+abort together
    bus.start = 1'b1;
    wr(3'd5, 32'd2);
    bus.start = 1'b0;
    chk("ab_start", 32'(bus.state), 32'd0);
    chk("ab_start_busy", 32'(bus.busy), 32'd0);
    wr(3'd5, 32'd3);
    chk("ab_go", 32'(bus.state), 32'd0);

    // CTRL go with SWEEP_CNT=0 goes straight to TRACK; busy blocks config writes
    wr(3'd2, 32'd0);
    wr(3'd5, 32'd1);
    chk("go_track", 32'(bus.state), 32'd2);
    chk("go_fll", 32'(bus.fll_en), 32'd1);
    chk("go_phi", bus.phi_inc, PHI0);
    wr(3'd0, 32'h1234_5678);
    wr(3'd5, 32'd2);
    step();
    chk("busy_wr_ign", bus.phi_inc, PHI0);

    // |-2^31| saturates; LOCK_LEN=0 locks on the first in-band sample
    wr(3'd3, 32'h7FFF_FFFF);
    wr(3'd4, 32'd0);
    wr(3'd5, 32'd1);
    model_init(PHI0, 64'sd2147483647, 0);
    trk_step(1'b1, 32'h8000_0000);
    chk("sat_in", 32'(bus.locked), 32'd1);
    trk_step(1'b0, 32'd0);
    wr(3'd5, 32'd2);
    wr(3'd3, 32'h7FFF_FFFE);
    wr(3'd5, 32'd1);
    model_init(PHI0, 64'sd2147483646, 0);
    trk_step(1'b1, 32'h8000_0000);
    chk("sat_out", 32'(bus.locked), 32'd0);
    trk_step(1'b1, 32'd0);
    chk("len0_lock", 32'(bus.locked), 32'd1);
    wr(3'd5, 32'd2);

    // PHI_INIT write in IDLE, then reset overriding start mid-operation
    wr(3'd0, 32'h0100_0000);
    step();
    chk("init_phi", bus.phi_inc, 32'h0100_0000);
    wr(3'd5, 32'd1);
    chk("init_track", bus.phi_inc, 32'h0100_0000);
    reset = 1'b1; bus.start = 1'b1; bus.delta_valid = 1'b1;
    step();
    reset = 1'b0; bus.start = 1'b0; bus.delta_valid = 1'b0;
    chk("mrst_state", 32'(bus.state), 32'd0);
    chk("mrst_phi", bus.phi_inc, PHI0);
    chk("mrst_busy", 32'(bus.busy), 32'd0);
    chk("mrst_nco", 32'(bus.nco_en), 32'd0);
    step();
    chk("mrst_init", bus.phi_inc, PHI0);
    chk("mrst_pv", 32'(bus.phi_valid), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/fll_lock_ctrl.md
FLL_LOCK_CTRL -- requirements
Module: fll_lock_ctrl

Interface
REQ-001 SHALL have parameter MULT, default 300_000: signed tracking gain applied to delta.
REQ-002 SHALL have parameter PHI_DEFAULT, default 36_151_557: reset value of PHI_INIT and phi_inc.
REQ-003 SHALL have parameter DWELL, default 64: cycles each sweep step is held.
REQ-004 SHALL have ports (name, direction, width, meaning):
- clk  in  1  single clock; one clock, all logic on posedge clk.
- reset  in  1  synchronous, active-high reset.
- wr_en  in  1  register write strobe.
- address  in  3  register select.
- data  in  32  write data.
- start  in  1  begin acquisition, one-cycle pulse.
- delta  in  32  signed frequency error from the FLL.
- delta_valid  in  1  delta qualifier.
- phi_inc  out  32  NCO phase increment.
- phi_valid  out  1  one-cycle pulse whenever phi_inc changes.
- fll_en  out  1  FLL enable.
- nco_en  out  1  NCO clock enable.
- locked  out  1  lock indicator.
- busy  out  1  high in any state except IDLE, FAIL.
- state  out  3  IDLE=0, SWEEP=1, TRACK=2, LOCKED=3, FAIL=4.

Function
REQ-005 SHALL decode registers on wr_en: 0 PHI_INIT, 1 STEP, 2 SWEEP_CNT[15:0], 3 LOCK_THR (unsigned), 4 LOCK_LEN[15:0], 5 CTRL (bit0 go = start, bit1 abort).
REQ-006 SHALL ignore writes to addresses 0-4 while busy; CTRL writes SHALL always be accepted; addresses 6-7 SHALL be ignored.
REQ-007 SHALL compute |delta| with |-2^31| saturating to 2^31-1; "in-band" means delta_valid and |delta| <= LOCK_THR.
REQ-008 IDLE: nco_en=0, fll_en=0, phi_inc=PHI_INIT; on start/go, SHALL go to SWEEP with k=0 if SWEEP_CNT!=0, else directly to TRACK.
REQ-009 SWEEP: nco_en=1, fll_en=0; SHALL hold phi_inc for DWELL cycles, latching in-band status of the most recent delta_valid within the dwell.
REQ-010 SWEEP end of dwell: if latched in-band, SHALL go to TRACK; else k<=k+1; if k+1==SWEEP_CNT, SHALL go to FAIL; else phi_inc <= phi_inc+STEP (mod 2^32), pulse phi_valid, restart dwell.
REQ-011 TRACK/LOCKED: nco_en=1, fll_en=1; on each delta_valid, SHALL register prod = MULT*delta (64-bit signed), then next cycle phi_inc <= phi_inc - prod[31:0] (mod 2^32) and pulse phi_valid: fixed 2-cycle latency, fully pipelined (one update per cycle sustained).
REQ-012 TRACK: SHALL count consecutive in-band samples; an out-of-band delta_valid SHALL clear the count; count reaching LOCK_LEN SHALL go to LOCKED (LOCK_LEN=0 treated as 1).
REQ-013 LOCKED: locked=1; an out-of-band delta_valid SHALL return to TRACK with count=0 and locked=0 on the next cycle.
REQ-014 FAIL: nco_en=0, fll_en=0, phi_inc held; start/go SHALL restart as from IDLE, reloading phi_inc=PHI_INIT.
REQ-015 Abort (CTRL bit1) SHALL force IDLE from any state next cycle, flush the multiply pipeline, and reload phi_inc=PHI_INIT; abort and start in the same cycle: abort wins.
REQ-016 start while busy SHALL be ignored.
REQ-017 Leaving TRACK/LOCKED SHALL discard any in-flight multiply product (no phi_inc update after exit).

Reset
REQ-018 On reset: PHI_INIT=PHI_DEFAULT, STEP=0, SWEEP_CNT=0, LOCK_THR=1000, LOCK_LEN=16, state=IDLE, phi_inc=PHI_DEFAULT, phi_valid=0, fll_en=0, nco_en=0, locked=0, busy=0, pipeline and counters cleared.
REQ-019 Reset mid-operation SHALL take effect on the next edge, overriding all other inputs.

Verification
REQ-020 Reset, no stimulus -> phi_inc=36_151_557, state=0, all flags 0.
REQ-021 SWEEP_CNT=3, STEP=1000, delta always 50_000 -> phi_inc steps +1000 twice at 64-cycle intervals, then state=FAIL after 192 cycles from start.
REQ-022 SWEEP_CNT=4, in-band delta=10 in second dwell -> TRACK entered at end of dwell 2 with phi_inc=PHI_INIT+1000.
REQ-023 TRACK, delta=2 valid one cycle -> phi_inc decreases by 600_000 exactly 2 cycles later with one phi_valid pulse; delta=-1 -> +300_000.
REQ-024 LOCK_LEN=16, 16 in-band samples then delta=5000 -> locked rises after 16th, falls the cycle after the out-of-band sample, state back to TRACK.
REQ-025 Abort written same cycle as start, and abort during LOCKED with delta_valid in flight -> state=IDLE, phi_inc=PHI_INIT, no further phi_valid.
